// File: rtl/fifo_pkg.sv
// fifo_pkg
// Shared constants and types for the FIFO read-side datapath.
//   SAMPLE_W      : audio sample width, default DATA_WIDTH of the read stream
//   RD_BUF_DEPTH  : number of entries in the read-side output buffer
//   sample_t      : one audio sample
//   rd_buf_next() : circular index increment over RD_BUF_DEPTH entries
package fifo_pkg;

  localparam int SAMPLE_W     = 24;
  localparam int RD_BUF_DEPTH = 3;

  typedef logic [SAMPLE_W-1:0] sample_t;

  // The buffer depth is not a power of two, so indices wrap explicitly.
  function automatic logic [1:0] rd_buf_next(input logic [1:0] idx);
    return (idx == 2'(RD_BUF_DEPTH - 1)) ? 2'd0 : idx + 2'd1;
  endfunction

endpackage

// File: rtl/fifo_rd_stream_if.sv
// fifo_rd_stream_if
// Valid/ready stream carrying samples from the FIFO read adapter to the
// audio datapath.
//   m_valid : word available (driven by master)
//   m_ready : consumer accepts the word on m_valid & m_ready (driven by slave)
//   m_data  : word, held stable while m_valid & ~m_ready (driven by master)
interface fifo_rd_stream_if
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = SAMPLE_W
);

  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;

  modport master (output m_valid, output m_data, input m_ready);
  modport slave  (input m_valid, input m_data, output m_ready);

endinterface

// File: rtl/rd_skid_buf.sv
// rd_skid_buf
// Three-entry circular buffer that absorbs words returned by block RAM so the
// pop request never depends combinationally on the downstream ready.
//   clk, reset : clock, synchronous active-high reset (clears contents too)
//   clear      : discard all buffered words (pointers and count only)
//   push       : write push_data at the tail
//   push_data  : word to store
//   pop        : advance the head (caller only pops when count != 0)
//   head_data  : word at the head
//   count      : number of buffered words, 0..3
module rd_skid_buf
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = SAMPLE_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic [1:0]            count
);

  logic [DATA_WIDTH-1:0] mem [RD_BUF_DEPTH];
  logic [1:0]            head;
  logic [1:0]            tail;

  // Pointer and occupancy bookkeeping; clear discards everything at once.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      head  <= 2'd0;
      tail  <= 2'd0;
      count <= 2'd0;
    end else begin
      if (push) tail <= rd_buf_next(tail);
      if (pop)  head <= rd_buf_next(head);
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  // Storage is zeroed only on reset so the output word reads as 0 afterwards;
  // a flush leaves stale contents that are hidden behind m_valid=0.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < RD_BUF_DEPTH; i++) mem[i] <= '0;
    end else if (push && !clear) begin
      mem[tail] <= push_data;
    end
  end

  assign head_data = mem[head];

endmodule

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream
// Read-side adapter between the FIFO pointer controller / block RAM and the
// audio datapath: turns rd/empty pops with one-cycle read latency into a
// registered valid/ready stream sustaining one word per cycle.
//   clk, reset : clock, synchronous active-high reset
//   fifo_empty : controller empty flag
//   fifo_rd    : pop request to the controller
//   fifo_rdata : storage data, valid the cycle after fifo_rd
//   flush      : discard buffered and in-flight words
//   m_if       : output stream (master modport)
//   level      : buffered word count, 0..3
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = SAMPLE_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fifo_empty,
  output logic                  fifo_rd,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  input  logic                  flush,
  fifo_rd_stream_if.master      m_if,
  output logic [1:0]            level
);

  logic       inflight;
  logic [1:0] count;
  logic [2:0] occupancy;
  logic       capture;
  logic       drain;

  // A pop is only issued when a buffer slot is reserved for its data, counting
  // the word still on its way back from block RAM. Only registered state and
  // the control inputs feed this, never m_ready.
  assign occupancy = {1'b0, count} + {2'b00, inflight};
  assign fifo_rd   = ~reset & ~flush & ~fifo_empty & (occupancy < 3'(RD_BUF_DEPTH));

  // Tracks that read data arrives next cycle; flush or reset abandons it.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      inflight <= 1'b0;
    end else begin
      inflight <= fifo_rd;
    end
  end

  assign capture      = inflight & ~flush;
  assign drain        = m_if.m_valid & m_if.m_ready;
  assign m_if.m_valid = (count != 2'd0);
  assign level        = count;

  rd_skid_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_buf (
    .clk      (clk),
    .reset    (reset),
    .clear    (flush),
    .push     (capture),
    .push_data(fifo_rdata),
    .pop      (drain),
    .head_data(m_if.m_data),
    .count    (count)
  );

  // Space reservation must never let buffered plus in-flight words exceed depth.
  a_no_overflow : assert property (@(posedge clk) disable iff (reset)
    occupancy <= 3'(RD_BUF_DEPTH));

endmodule

// File: doc/fifo_rd_stream.md
# fifo_rd_stream

Read-side adapter placed directly downstream of the FIFO pointer controller and its block-RAM storage. It turns the controller's `rd`/`empty` pop interface, plus storage data returned one cycle after the pop, into a registered valid/ready stream for the downstream audio datapath. A 3-entry output buffer sustains one word per cycle with no combinational path from `m_ready` to `fifo_rd`.

## Interface
- `DATA_WIDTH`, 24, sample width in bits.

- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `fifo_empty`  in  1  controller `empty` flag (registered in the controller).
- `fifo_rd`  out  1  pop request to the controller's `rd` input.
- `fifo_rdata`  in  DATA_WIDTH  storage read data, valid the cycle after `fifo_rd`=1.
- `flush`  in  1  synchronous discard of all buffered and in-flight words.
- `m_valid`  out  1  output word available.
- `m_ready`  in  1  consumer accepts the word when `m_valid & m_ready`.
- `m_data`  out  DATA_WIDTH  output word; stable while `m_valid & ~m_ready`.
- `level`  out  2  buffered word count, 0..3.

## Operation
- State: 3-entry circular buffer (`head`, `tail`, `count`), plus `inflight` (1 bit, set the cycle after `fifo_rd`=1).
- Pop issue: `fifo_rd = ~reset & ~flush & ~fifo_empty & (count + inflight < 3)`. `count` and `inflight` are registered values, so `fifo_rd` depends only on registers and `fifo_empty`/`flush`/`reset`. `fifo_rd` is never asserted while `fifo_empty`=1.
- Capture: when `inflight`=1 and `flush`=0, write `fifo_rdata` at `tail`, then `tail` ← `tail`+1 mod 3.
- Drain: `m_valid = (count != 0)`, `m_data = buf[head]`. On `m_valid & m_ready`, `head` ← `head`+1 mod 3.
- Count update: `count` ← `count` + capture − drain. Simultaneous capture and drain leave `count` unchanged. Capture into a full buffer cannot occur, because the issue rule reserves space; the assertion `count + inflight <= 3` holds always.
- Wrap-around: `head` and `tail` wrap 2→0. No power-of-two assumption.
- Flush: has priority over capture and issue.
  - `count`, `head`, `tail` and `inflight` ← 0.
  - Forces `fifo_rd`=0 in the flush cycle.
  - Data arriving in the flush cycle is dropped. That word is lost, because the controller pointer has already advanced.
  - `m_valid` falls the cycle after flush.
- Reset: `count`=0, `head`=`tail`=0, `inflight`=0, `m_valid`=0, `m_data`=0 (buffer cleared), `level`=0, `fifo_rd`=0 while `reset`=1.
- A reset asserted mid-transfer abandons any in-flight word, as flush does.

## Timing
- First-word latency: `fifo_empty` falls before cycle N → `fifo_rd`=1 in N → capture at the end of N+1 → `m_valid`=1 in N+2.
- Throughput: with a continuous `m_ready`=1 and a non-empty FIFO, steady state is `count`=1 and `inflight`=1, giving one `fifo_rd` and one output word per cycle.
- Backpressure: with `m_ready`=0, at most 3 words are popped before `fifo_rd` stays low. Issue resumes the cycle after the first accept.
- `level` equals `count` (registered), with no lookahead.

## Structure
- Shared package `fifo_pkg`:
  - `SAMPLE_W` = 24, used as the `DATA_WIDTH` default.
  - `RD_BUF_DEPTH` = 3.
  - typedef `sample_t` = `logic [SAMPLE_W-1:0]`.
- One natural sub-module: `rd_skid_buf`, the 3-entry circular buffer with push/pop/count.
- The top level holds the issue logic, `inflight` and flush sequencing.

## Test plan
- **Reset:** hold `reset` 2 cycles with `fifo_empty`=0 → `fifo_rd`=0, `m_valid`=0, `m_data`=0, `level`=0 throughout; `fifo_rd`=1 the first cycle after release.
- **Streaming:** FIFO model preloaded with 0x000001..0x000010, `m_ready`=1 → `m_data` sequence 0x000001..0x000010 on consecutive cycles, first word at cycle 2 after release, no gaps, no duplicates.
- **Backpressure:** `m_ready`=0 with 8 words queued → exactly 3 pops, `level`=3, `m_data`=first word held stable. Raising `m_ready` then delivers the remaining words in order.
- **Empty boundary:** FIFO holds 1 word → exactly one `fifo_rd`, `m_valid` high 1 cycle, and `fifo_rd` never asserted while `fifo_empty`=1.
- **Flush mid-flight:** `level`=2, `inflight`=1, `flush` pulsed 1 cycle → `m_valid`=0 next cycle and the in-flight word is never output. Next output is the word after it.
- **Wrap and simultaneity:** 50 words with random `m_ready` → output order equals input order, `level` ≤ 3, `head`/`tail` wrap observed; capture and drain in the same cycle keep `level` constant.
